// File: rtl/vector_alu_driver.sv
// vector_alu_driver: initiator side of the 4-lane vector ALU interface.
// Gathers scalar operand pairs lane by lane and presents them to the ALU as
// packed vectors. After one execute cycle it captures the vector result, and
// then hands the lanes back out one at a time on a valid/ready stream.
module vector_alu_driver #(
  parameter int vector       = 4,
  parameter int bus          = 4,
  parameter int bus_selector = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [bus-1:0]            in_a,
  input  logic [bus-1:0]            in_b,
  input  logic [bus_selector-1:0]   in_op,
  output logic [vector*bus-1:0]     alu_a,
  output logic [vector*bus-1:0]     alu_b,
  output logic [bus_selector-1:0]   alu_selector,
  input  logic [vector*bus-1:0]     alu_result,
  input  logic [vector-1:0]         alu_carry,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [bus-1:0]            out_data,
  output logic                      out_carry,
  output logic [$clog2(vector)-1:0] out_lane,
  output logic                      out_last,
  output logic                      busy
);

  localparam int cnt_w = $clog2(vector);
  localparam logic [cnt_w-1:0] last_lane = cnt_w'(vector - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    EXEC  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [cnt_w-1:0]          cnt_q, cnt_d;
  logic [vector*bus-1:0]     alu_a_q, alu_a_d;
  logic [vector*bus-1:0]     alu_b_q, alu_b_d;
  logic [bus_selector-1:0]   sel_q, sel_d;
  logic [vector*bus-1:0]     result_q, result_d;
  logic [vector-1:0]         carry_q, carry_d;

  logic draining;

  // Load and drain never overlap, so the upstream handshake is only open in LOAD.
  assign in_ready = (state_q == LOAD) && !rst;
  assign draining = (state_q == DRAIN);

  // Next-state logic: lane writes in LOAD, one-cycle result capture in EXEC,
  // and lane-by-lane handoff in DRAIN. The lane counter is shared by LOAD and DRAIN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    sel_d    = sel_q;
    result_d = result_q;
    carry_d  = carry_q;
    case (state_q)
      LOAD: begin
        if (in_valid && in_ready) begin
          alu_a_d[int'(cnt_q)*bus +: bus] = in_a;
          alu_b_d[int'(cnt_q)*bus +: bus] = in_b;
          if (cnt_q == '0) begin
            sel_d = in_op;
          end
          if (cnt_q == last_lane) begin
            cnt_d   = '0;
            state_d = EXEC;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end
      end
      EXEC: begin
        result_d = alu_result;
        for (int i = 0; i < vector; i++) begin
          carry_d[i] = alu_carry[vector-1-i];
        end
        state_d = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          if (cnt_q == last_lane) begin
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset abandons any partial transaction and clears all operands and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      sel_q    <= '0;
      result_q <= '0;
      carry_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_selector = sel_q;

  // Downstream outputs are decoded purely from registers, so they hold steady under backpressure.
  assign out_valid = draining;
  assign out_data  = draining ? result_q[int'(cnt_q)*bus +: bus] : '0;
  assign out_carry = draining && carry_q[cnt_q];
  assign out_lane  = draining ? cnt_q : '0;
  assign out_last  = draining && (cnt_q == last_lane);
  assign busy      = (state_q != LOAD) || (cnt_q != '0);

endmodule

// File: tb/tb_vector_alu_driver.sv
// tb_vector_alu_driver: directed bench for vector_alu_driver.
// A behavioural 4-lane ALU sits on the driver's ALU port. A per-lane scoreboard
// computes the expected results and checks every presented output lane.
module tb_vector_alu_driver;

  localparam int vector       = 4;
  localparam int bus          = 4;
  localparam int bus_selector = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [bus-1:0]          in_a = '0;
  logic [bus-1:0]          in_b = '0;
  logic [bus_selector-1:0] in_op = '0;
  logic [vector*bus-1:0]   alu_a;
  logic [vector*bus-1:0]   alu_b;
  logic [bus_selector-1:0] alu_selector;
  logic [vector*bus-1:0]   alu_result;
  logic [vector-1:0]       alu_carry;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [bus-1:0]          out_data;
  logic                    out_carry;
  logic [1:0]              out_lane;
  logic                    out_last;
  logic                    busy;

  vector_alu_driver #(
    .vector(vector), .bus(bus), .bus_selector(bus_selector)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_selector(alu_selector),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry),
    .out_lane(out_lane), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] data;
    logic       carry;
    logic [1:0] lane;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] obs_data [4];
  logic       obs_carry [4];
  int         checks_total  = 0;
  int         checks_passed = 0;

  // One ALU lane: {carry, 4-bit result}. Add carry is the fifth sum bit.
  // Sub carry is the borrow. Mul carry flags a product above 15. Op 3 gives 0.
  function automatic logic [4:0] lane_op(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    logic [7:0] p;
    p = {4'b0, a} * {4'b0, b};
    case (op[1:0])
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {(a < b), 4'(a - b)};
      2'd2:    return {(p > 8'd15), p[3:0]};
      default: return 5'd0;
    endcase
  endfunction

  // Behavioural vector ALU; carries come back lane-reversed.
  logic [4:0] stub_r;
  always_comb begin
    alu_result = '0;
    alu_carry  = '0;
    stub_r     = '0;
    for (int i = 0; i < vector; i++) begin
      stub_r = lane_op(alu_selector, alu_a[i*4 +: 4], alu_b[i*4 +: 4]);
      alu_result[i*4 +: 4] = stub_r[3:0];
      alu_carry[vector-1-i] = stub_r[4];
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Scoreboard: every presented lane must match the head of the expected queue.
  // When nothing is expected, out_valid must stay low.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() == 0) begin
        check_output("out_valid_idle", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        check_output("out_data", 32'(out_data), 32'(exp_q[0].data));
        check_output("out_carry", 32'(out_carry), 32'(exp_q[0].carry));
        check_output("out_lane", 32'(out_lane), 32'(exp_q[0].lane));
        check_output("out_last", 32'(out_last), 32'(exp_q[0].last));
        if (out_ready) begin
          obs_data[out_lane]  = out_data;
          obs_carry[out_lane] = out_carry;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Offers one lane and returns one tick after the edge that accepted it.
  task automatic send_lane(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Queues the expected lanes of one transaction, then feeds its four lanes.
  // The lane-0 check confirms that the selector passes through unchanged.
  task automatic apply_stimulus(input logic [3:0] op, input logic [15:0] a,
                                input logic [15:0] b, input int gap);
    logic [4:0] r;
    exp_t       e;
    for (int i = 0; i < vector; i++) begin
      r = lane_op(op, a[i*4 +: 4], b[i*4 +: 4]);
      e.data  = r[3:0];
      e.carry = r[4];
      e.lane  = 2'(i);
      e.last  = (i == vector - 1);
      exp_q.push_back(e);
    end
    for (int i = 0; i < vector; i++) begin
      send_lane(a[i*4 +: 4], b[i*4 +: 4], op);
      if (i == 0) check_output("selector_lane0", 32'(alu_selector), 32'(op));
      if (i == 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check_output("gap_in_ready", 32'(in_ready), 32'd1);
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lane(input logic [1:0] lane);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid && out_lane == lane) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("lane_wait_timeout", 32'd0, 32'd1);
  endtask

  // Hand-computed per-lane literals that pin the scoreboard's arithmetic.
  task automatic check_lits(input string tag, input logic [15:0] data_exp,
                            input logic [3:0] carry_exp, input bit chk_carry);
    for (int i = 0; i < vector; i++) begin
      check_output($sformatf("%s_data%0d", tag, i), 32'(obs_data[i]), 32'(data_exp[i*4 +: 4]));
      if (chk_carry)
        check_output($sformatf("%s_carry%0d", tag, i), 32'(obs_carry[i]), 32'(carry_exp[i]));
    end
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_alu_a", 32'(alu_a), 32'd0);
    check_output("rst_alu_b", 32'(alu_b), 32'd0);
    check_output("rst_selector", 32'(alu_selector), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_last", 32'(out_last), 32'd0);
    check_output("rst_out_data", 32'(out_data), 32'd0);
    check_output("rst_out_lane", 32'(out_lane), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Add: a={1,2,3,15}, b=1. Also checks the latency and the held operands.
    apply_stimulus(4'd0, 16'hF321, 16'h1111, 0);
    @(negedge clk);
    check_output("exec_out_valid", 32'(out_valid), 32'd0);
    check_output("exec_busy", 32'(busy), 32'd1);
    check_output("exec_in_ready", 32'(in_ready), 32'd0);
    check_output("exec_alu_a", 32'(alu_a), 32'h0000F321);
    check_output("exec_alu_b", 32'(alu_b), 32'h00001111);
    @(negedge clk);
    check_output("latency_out_valid", 32'(out_valid), 32'd1);
    check_output("latency_out_lane", 32'(out_lane), 32'd0);
    wait_drain();
    check_lits("add", 16'h0432, 4'b1000, 1'b1);

    // Mul: a={2,3,4,15}, b={3,5,4,2}.
    apply_stimulus(4'd2, 16'hF432, 16'h2453, 0);
    wait_drain();
    check_lits("mul", 16'hE0F6, 4'b1100, 1'b1);

    // Sub with a two-cycle input gap after lane 1.
    apply_stimulus(4'd1, 16'h7035, 16'h7132, 2);
    wait_drain();
    check_lits("sub", 16'h0F03, 4'b0000, 1'b0);

    // Backpressure: lane 1 is held for three cycles.
    apply_stimulus(4'd0, 16'h7654, 16'h9321, 0);
    wait_lane(2'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("stall_in_ready", 32'(in_ready), 32'd0);
      check_output("stall_out_lane", 32'(out_lane), 32'd1);
      check_output("stall_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    check_lits("bp", 16'h0975, 4'b1000, 1'b1);

    // Reserved op, followed by an add whose upper selector bits are set.
    apply_stimulus(4'd3, 16'hABCD, 16'h1234, 0);
    wait_drain();
    check_lits("rsv", 16'h0000, 4'b0000, 1'b1);
    apply_stimulus(4'd4, 16'h1111, 16'h2222, 0);
    wait_drain();
    check_lits("after_rsv", 16'h3333, 4'b0000, 1'b1);

    // Reset pulse right after lane 1 has been handed out.
    apply_stimulus(4'd0, 16'h8421, 16'h8888, 0);
    wait_lane(2'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("abort_out_valid", 32'(out_valid), 32'd0);
    check_output("abort_in_ready", 32'(in_ready), 32'd1);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_out_lane", 32'(out_lane), 32'd0);
    @(posedge clk);
    #1;
    apply_stimulus(4'd0, 16'h1234, 16'h4321, 0);
    wait_drain();
    check_lits("fresh", 16'h5555, 4'b0000, 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vector_alu_driver.md
Name: vector_alu_driver

Overview:
- Initiator side of the 4-lane vector ALU interface.
- Collects scalar operand pairs one lane per cycle from an upstream valid/ready stream and assembles them into packed vector operands.
- Drives the ALU operands and selector, captures the vector result and per-lane carry flags, then serializes them back out one lane per cycle to a downstream valid/ready stream.
- Sits between the scalar register-file/load path and the combinational vector ALU.

Parameters:
- vector, 4, number of lanes per transaction
- bus, 4, lane element width in bits
- bus_selector, 4, ALU selector width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream lane element valid
- in_ready  out  1  driver accepts lane element
- in_a  in  bus  operand A element
- in_b  in  bus  operand B element
- in_op  in  bus_selector  operation; sampled only with lane 0
- alu_a  out  vector*bus  packed operand A; lane i at bits [i*bus +: bus]
- alu_b  out  vector*bus  packed operand B, same packing
- alu_selector  out  bus_selector  selector to ALU
- alu_result  in  vector*bus  ALU vector result, same packing
- alu_carry  in  vector  ALU carry flags, lane-reversed (lane i at bit vector-1-i)
- out_valid  out  1  result element valid
- out_ready  in  1  downstream accepts element
- out_data  out  bus  result element
- out_carry  out  1  carry flag of the presented lane
- out_lane  out  $clog2(vector)  index of the presented lane
- out_last  out  1  presented lane is vector-1
- busy  out  1  state != LOAD or lane count != 0

Behaviour:
- States: LOAD, EXEC, DRAIN. Reset forces LOAD and lane counter 0.
- Reset values: alu_a, alu_b, alu_selector, out_data, out_carry and out_lane are 0; out_valid and out_last are 0; busy is 0.
- in_ready = (state==LOAD) && !rst. It is 0 in EXEC and DRAIN; there is no overlap between load and drain.
- LOAD:
  - On in_valid && in_ready, write in_a/in_b into lane cnt of the alu_a/alu_b registers.
  - On lane 0, also register in_op into alu_selector.
  - Increment cnt. Gaps with in_valid=0 hold all state.
  - On acceptance of lane vector-1, cnt wraps to 0 and the state goes to EXEC.
- EXEC:
  - Exactly one cycle; ALU inputs are stable from registers.
  - At its end, capture alu_result into the result register and de-reverse alu_carry into the carry register (carry_reg[i] = alu_carry[vector-1-i]).
  - Then go to DRAIN.
- DRAIN:
  - out_valid=1; out_data = result_reg lane cnt; out_carry = carry_reg[cnt]; out_lane = cnt; out_last = (cnt==vector-1).
  - On out_valid && out_ready, increment cnt.
  - While out_ready=0, all outputs stay stable.
  - After lane vector-1 transfers, cnt = 0, state goes to LOAD, out_valid drops the next cycle.
- Latency: last input accepted at edge N → EXEC during cycle N+1 → out_valid=1 from cycle N+2. With no stalls, a full transaction takes 2*vector+1 cycles.
- alu_a, alu_b and alu_selector hold their values from the end of LOAD until overwritten by the next transaction's lane writes.
- Operation codes use selector[1:0]:
  - 0 add, 1 sub, 2 mul, 3 reserved (ALU returns 0).
  - The driver passes in_op unchanged; the upper selector bits are don't-care.
- Width: results are bus bits, truncated by the ALU; overflow is signalled only through the carry flag.
- Reset mid-operation (any state) aborts the transaction. Partial operands and results are discarded, and the next cycle is LOAD with cnt=0.

Test Plan:
- Add, bus=4:
  - Stimulus: op=0, lanes a={1,2,3,15}, b={1,1,1,1}, no stalls.
  - Response: out_valid from cycle N+2; out_data 2,3,4,0 on lanes 0..3; out_carry 0,0,0,1; out_last only on lane 3.
- Mul:
  - Stimulus: op=2, a={2,3,4,15}, b={3,5,4,2}.
  - Response: out_data 6,15,0,14; out_carry 0,0,1,1, which checks carry de-reversal.
- Sub with input gaps:
  - Stimulus: op=1, a={5,3,0,7}, b={2,3,1,7}, in_valid low for 2 cycles between lanes 1 and 2.
  - Response: no lane skipped or duplicated; out_data 3,0,15,0; in_ready stays 1 throughout the gap.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while lane 1 is presented.
  - Response: out_data, out_lane=1 and out_carry are held stable; in_ready stays 0; lanes 2,3 follow after out_ready rises.
- Reserved op:
  - Stimulus: op=3 with any operands.
  - Response: out_data 0 on all four lanes; the next transaction (op=0) is unaffected and alu_selector is updated at its lane 0.
- Reset mid-drain:
  - Stimulus: assert rst for 1 cycle after lane 1 is output.
  - Response: next cycle out_valid=0, in_ready=1, busy=0, out_lane=0; a fresh add transaction completes correctly.
